// File: rtl/bids22_round_recorder_pkg.sv
// Shared types and widths for the bids22 round recorder: result status, FIFO entry
// layout and the round classifier.
package bids22_round_recorder_pkg;

    localparam int DATAWIDTH  = 32;
    localparam int NUMBIDDERS = 3;
    localparam int DEPTH      = 8;
    localparam int CNTW       = 16;
    localparam int REVW       = 40;
    localparam int WINW       = (NUMBIDDERS > 1) ? $clog2(NUMBIDDERS) : 1;

    typedef enum logic [1:0] {
        REC_OK       = 2'd0,
        REC_NOWIN    = 2'd1,
        REC_MULTIWIN = 2'd2
    } rec_status_t;

    typedef struct packed {
        rec_status_t           status;
        logic [WINW-1:0]       winner;
        logic [DATAWIDTH-1:0]  amount;
        logic [CNTW-1:0]       round;
    } rec_entry_t;

    // Winner and amount are only meaningful for a single winner with a non-zero bid.
    function automatic rec_entry_t classify(input logic [NUMBIDDERS-1:0] wv,
                                            input logic [DATAWIDTH-1:0]  bid,
                                            input logic [CNTW-1:0]       rnd);
        rec_entry_t  e;
        int unsigned ones;
        logic [WINW-1:0] idx;
        ones = 32'd0;
        idx  = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (wv[i]) begin
                ones = ones + 32'd1;
                idx  = WINW'(i);
            end
        end
        e.round = rnd;
        if (ones == 32'd0 || bid == '0) begin
            e.status = REC_NOWIN;
            e.winner = '0;
            e.amount = '0;
        end else if (ones > 32'd1) begin
            e.status = REC_MULTIWIN;
            e.winner = '0;
            e.amount = '0;
        end else begin
            e.status = REC_OK;
            e.winner = idx;
            e.amount = bid;
        end
        return e;
    endfunction

endpackage

// File: rtl/bids22_round_recorder_if.sv
// Read-side valid/ready bus of the round recorder result FIFO.
interface bids22_round_recorder_if;
    import bids22_round_recorder_pkg::*;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [WINW-1:0]       rd_winner;
    rec_status_t           rd_status;
    logic [DATAWIDTH-1:0]  rd_amount;
    logic [CNTW-1:0]       rd_round;

    modport master (input  rd_valid, rd_winner, rd_status, rd_amount, rd_round,
                    output rd_ready);
    modport slave  (output rd_valid, rd_winner, rd_status, rd_amount, rd_round,
                    input  rd_ready);
endinterface

// File: rtl/bids22_result_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module bids22_result_fifo
    import bids22_round_recorder_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = rec_entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    T            mem_r [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty;
    // When full, a simultaneous pop frees the head slot that this push overwrites.
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = empty ? T'('0) : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update with reset and soft clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
        end
    end

    // Entry storage; contents are invisible until the write pointer passes them.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/bids22_round_recorder.sv
// Captures bids22 round results on the rising edge of round_over, classifies them,
// queues them for a valid/ready reader and keeps win/round/revenue/drop statistics.
module bids22_round_recorder
    import bids22_round_recorder_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        round_over,
    input  logic [DATAWIDTH-1:0]        max_bid,
    input  logic [NUMBIDDERS-1:0]       win_vec,
    bids22_round_recorder_if.slave      rd,
    output logic [NUMBIDDERS*CNTW-1:0]  win_count,
    output logic [CNTW-1:0]             round_count,
    output logic [REVW-1:0]             revenue,
    output logic [CNTW-1:0]             drop_count,
    output logic                        overflow
);
    logic                        prev_ro_r;
    logic [NUMBIDDERS*CNTW-1:0]  win_count_r;
    logic [CNTW-1:0]             round_count_r;
    logic [REVW-1:0]             revenue_r;
    logic [CNTW-1:0]             drop_count_r;
    logic                        overflow_r;

    logic                        capture_s;
    logic                        pop_s;
    logic                        push_s;
    logic                        drop_s;
    logic                        full_s;
    logic                        empty_s;
    logic                        ok_s;
    rec_entry_t                  entry_s;
    rec_entry_t                  head_s;
    logic [NUMBIDDERS*CNTW-1:0]  win_next_s;
    logic [REVW:0]               rev_sum_s;
    logic [REVW-1:0]             rev_next_s;

    assign capture_s = round_over && !prev_ro_r;
    assign entry_s   = classify(win_vec, max_bid, round_count_r);
    assign ok_s      = capture_s && (entry_s.status == REC_OK);
    assign pop_s     = !empty_s && rd.rd_ready;
    assign push_s    = capture_s && (!full_s || pop_s);
    assign drop_s    = capture_s && full_s && !pop_s;

    bids22_result_fifo #(.DEPTH(DEPTH), .T(rec_entry_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Saturating next values for the winner's counter and the revenue total.
    always_comb begin
        win_next_s = win_count_r;
        rev_sum_s  = {1'b0, revenue_r} + (REVW+1)'(max_bid);
        rev_next_s = revenue_r;
        if (ok_s) begin
            if (win_count_r[entry_s.winner*CNTW +: CNTW] != {CNTW{1'b1}}) begin
                win_next_s[entry_s.winner*CNTW +: CNTW] = win_count_r[entry_s.winner*CNTW +: CNTW] + 1'b1;
            end else begin
                win_next_s = win_count_r;
            end
            rev_next_s = rev_sum_s[REVW] ? {REVW{1'b1}} : rev_sum_s[REVW-1:0];
        end else begin
            rev_next_s = revenue_r;
        end
    end

    // Edge detect and statistics registers.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_ro_r     <= 1'b0;
            win_count_r   <= '0;
            round_count_r <= '0;
            revenue_r     <= '0;
            drop_count_r  <= '0;
            overflow_r    <= 1'b0;
        end else begin
            prev_ro_r   <= round_over;
            win_count_r <= win_next_s;
            revenue_r   <= rev_next_s;
            if (capture_s) round_count_r <= round_count_r + 1'b1;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != {CNTW{1'b1}}) drop_count_r <= drop_count_r + 1'b1;
            end
        end
    end

    assign rd.rd_valid  = !empty_s;
    assign rd.rd_winner = head_s.winner;
    assign rd.rd_status = head_s.status;
    assign rd.rd_amount = head_s.amount;
    assign rd.rd_round  = head_s.round;

    assign win_count   = win_count_r;
    assign round_count = round_count_r;
    assign revenue     = revenue_r;
    assign drop_count  = drop_count_r;
    assign overflow    = overflow_r;
endmodule

// File: tb/tb_bids22_round_recorder.sv
// Directed self-checking bench for bids22_round_recorder.
module tb_bids22_round_recorder;
    import bids22_round_recorder_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        clear;
    logic                        round_over;
    logic [DATAWIDTH-1:0]        max_bid;
    logic [NUMBIDDERS-1:0]       win_vec;
    logic [NUMBIDDERS*CNTW-1:0]  win_count;
    logic [CNTW-1:0]             round_count;
    logic [REVW-1:0]             revenue;
    logic [CNTW-1:0]             drop_count;
    logic                        overflow;

    int n_cmp = 0;
    int n_err = 0;

    bids22_round_recorder_if rif ();

    bids22_round_recorder dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .round_over  (round_over),
        .max_bid     (max_bid),
        .win_vec     (win_vec),
        .rd          (rif),
        .win_count   (win_count),
        .round_count (round_count),
        .revenue     (revenue),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NUMBIDDERS-1:0] wv, input logic [DATAWIDTH-1:0] bid);
        round_over = 1'b1;
        win_vec    = wv;
        max_bid    = bid;
        tick();
        round_over = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; round_over = 1'b0;
        max_bid = 32'd0; win_vec = 3'b000; rif.rd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_valid",    64'(rif.rd_valid), 64'd0);
        chk("rst_amount",   64'(rif.rd_amount), 64'd0);
        chk("rst_rounds",   64'(round_count), 64'd0);
        chk("rst_revenue",  64'(revenue), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // 1: single pulse, visible one cycle after capture edge
        round_over = 1'b1; win_vec = 3'b010; max_bid = 32'd25;
        tick();
        round_over = 1'b0;
        chk("t1_valid",  64'(rif.rd_valid), 64'd1);
        chk("t1_winner", 64'(rif.rd_winner), 64'd1);
        chk("t1_status", 64'(rif.rd_status), 64'(REC_OK));
        chk("t1_amount", 64'(rif.rd_amount), 64'd25);
        chk("t1_round",  64'(rif.rd_round), 64'd0);
        chk("t1_win1",   64'(win_count[1*CNTW +: CNTW]), 64'd1);
        chk("t1_rev",    64'(revenue), 64'd25);
        rif.rd_ready = 1'b1;
        tick();
        rif.rd_ready = 1'b0;
        chk("t1_popped", 64'(rif.rd_valid), 64'd0);

        // 2: level held high for 4 cycles captures once
        round_over = 1'b1; win_vec = 3'b001; max_bid = 32'd7;
        tick(); tick(); tick(); tick();
        round_over = 1'b0;
        tick();
        chk("t2_rounds", 64'(round_count), 64'd2);
        chk("t2_round",  64'(rif.rd_round), 64'd1);
        chk("t2_amount", 64'(rif.rd_amount), 64'd7);
        chk("t2_win0",   64'(win_count[0 +: CNTW]), 64'd1);
        chk("t2_rev",    64'(revenue), 64'd32);
        rif.rd_ready = 1'b1;
        tick();
        rif.rd_ready = 1'b0;
        chk("t2_one_entry", 64'(rif.rd_valid), 64'd0);

        // 3: no winner, then multiple winners
        pulse(3'b000, 32'd50);
        pulse(3'b101, 32'd9);
        chk("t3_nowin_st",  64'(rif.rd_status), 64'(REC_NOWIN));
        chk("t3_nowin_amt", 64'(rif.rd_amount), 64'd0);
        chk("t3_nowin_rnd", 64'(rif.rd_round), 64'd2);
        rif.rd_ready = 1'b1;
        tick();
        rif.rd_ready = 1'b0;
        chk("t3_multi_st",  64'(rif.rd_status), 64'(REC_MULTIWIN));
        chk("t3_multi_amt", 64'(rif.rd_amount), 64'd0);
        chk("t3_multi_win", 64'(rif.rd_winner), 64'd0);
        chk("t3_multi_rnd", 64'(rif.rd_round), 64'd3);
        chk("t3_rev",       64'(revenue), 64'd32);
        chk("t3_rounds",    64'(round_count), 64'd4);

        // 4: overflow with reader stalled, then in-order drain
        do_clear();
        tick();
        chk("t4_clr_rounds", 64'(round_count), 64'd0);
        for (int i = 0; i < 10; i++) pulse(3'b100, 32'(i + 1));
        chk("t4_drops",    64'(drop_count), 64'd2);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_rounds",   64'(round_count), 64'd10);
        chk("t4_rev",      64'(revenue), 64'd55);
        chk("t4_win2",     64'(win_count[2*CNTW +: CNTW]), 64'd10);
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_rnd", 64'(rif.rd_round), 64'(i));
            chk("t4_drain_amt", 64'(rif.rd_amount), 64'(i + 1));
            tick();
        end
        rif.rd_ready = 1'b0;
        chk("t4_empty", 64'(rif.rd_valid), 64'd0);

        // 5: full FIFO, pop and capture in the same cycle
        do_clear();
        for (int i = 0; i < 8; i++) pulse(3'b001, 32'(i + 1));
        round_over = 1'b1; win_vec = 3'b010; max_bid = 32'd99; rif.rd_ready = 1'b1;
        tick();
        round_over = 1'b0; rif.rd_ready = 1'b0;
        chk("t5_drops",    64'(drop_count), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        chk("t5_head",     64'(rif.rd_round), 64'd1);
        rif.rd_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            chk("t5_drain_rnd", 64'(rif.rd_round), 64'(i));
            tick();
        end
        rif.rd_ready = 1'b0;
        chk("t5_empty", 64'(rif.rd_valid), 64'd0);
        // the last entry read above must have been the 99 bid from bidder 1
        chk("t5_win1", 64'(win_count[1*CNTW +: CNTW]), 64'd1);
        chk("t5_rev",  64'(revenue), 64'd135);

        // 6: clear with 3 entries queued and overflow set
        do_clear();
        for (int i = 0; i < 10; i++) pulse(3'b010, 32'd3);
        rif.rd_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        rif.rd_ready = 1'b0;
        chk("t6_queued",   64'(rif.rd_valid), 64'd1);
        chk("t6_head_rnd", 64'(rif.rd_round), 64'd5);
        chk("t6_pre_ovf",  64'(overflow), 64'd1);
        do_clear();
        chk("t6_valid",    64'(rif.rd_valid), 64'd0);
        chk("t6_rounds",   64'(round_count), 64'd0);
        chk("t6_wins",     64'(win_count), 64'd0);
        chk("t6_rev",      64'(revenue), 64'd0);
        chk("t6_drops",    64'(drop_count), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
